// File: rtl/wb_arbiter3.sv
// Round-robin arbiter for the 3-input write-back mux: registered one-hot grant plus mux select.
// Define WB_ARB3_HOLD_LIMIT_EN to compile in the MAX_HOLD preemption of a contended owner.
module wb_arbiter3 #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] req,
   output logic [2:0] gnt,
   output logic [1:0] sel,
   output logic       busy,
   output logic [1:0] owner
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   if (MAX_HOLD < 2) begin : g_max_hold_chk
      $error("MAX_HOLD must be at least 2");
   end

   state_t     state_q;
   logic [2:0] gnt_q;
   logic [1:0] owner_q;
   logic [1:0] last_q;

`ifdef WB_ARB3_HOLD_LIMIT_EN
   localparam int CW = $clog2(MAX_HOLD);
   logic [CW-1:0] cnt_q;
`endif

   logic [2:0] cand;
   logic       leave;
   logic       win_vld;
   logic [1:0] win_idx;

   // First set bit of r, searching from last+1 and wrapping through 2 -> 0 -> 1.
   function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
      logic [2:0] res;
      logic [1:0] idx;
      res = '0;
      for (int k = 3; k >= 1; k--) begin
         idx = 2'((int'(last) + k) % 3);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      cand  = req;
      leave = 1'b1;
      if (state_q == GRANT) begin
         cand  = req & ~gnt_q;
         leave = ~req[owner_q];
`ifdef WB_ARB3_HOLD_LIMIT_EN
         if (cnt_q == CW'(MAX_HOLD - 1) && cand != 3'b000) leave = 1'b1;
`endif
      end
   end

   assign {win_vld, win_idx} = rr_pick(cand, last_q);

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         gnt_q   <= 3'b000;
         owner_q <= 2'd0;
         last_q  <= 2'd2;
`ifdef WB_ARB3_HOLD_LIMIT_EN
         cnt_q   <= '0;
`endif
      end else if (leave) begin
         if (win_vld) begin
            state_q <= GRANT;
            gnt_q   <= 3'b001 << win_idx;
            owner_q <= win_idx;
            last_q  <= win_idx;
`ifdef WB_ARB3_HOLD_LIMIT_EN
            cnt_q   <= '0;
`endif
         end else begin
            // Owner and select hold their values so the mux never moves without a grant.
            state_q <= IDLE;
            gnt_q   <= 3'b000;
         end
      end else begin
`ifdef WB_ARB3_HOLD_LIMIT_EN
         if (cnt_q != CW'(MAX_HOLD - 1)) cnt_q <= cnt_q + 1'b1;
`endif
      end
   end

   assign gnt   = gnt_q;
   assign sel   = owner_q;
   assign busy  = (state_q == GRANT);
   assign owner = owner_q;

endmodule

// File: tb/tb_wb_arbiter3.sv
// Self-checking bench for wb_arbiter3: directed steps plus random traffic against a run-length model.
module tb_wb_arbiter3;

   localparam int MAX_HOLD = 4;

   logic       clk;
   logic       reset_n;
   logic [2:0] req;
   logic [2:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic [1:0] owner;

   int checks = 0;
   int errors = 0;

   // Reference model: current owner (-1 = none), rotation pointer, visible owner, grant run length.
   int m_own;
   int m_last;
   int m_owner;
   int m_run;

   wb_arbiter3 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .req    (req),
      .gnt    (gnt),
      .sel    (sel),
      .busy   (busy),
      .owner  (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_own   = -1;
      m_last  = 2;
      m_owner = 0;
      m_run   = 0;
   endtask

   task automatic model_step(input logic [2:0] r);
      logic [2:0] pool;
      bit         leave;
      int         nxt;
      pool = r;
      if (m_own < 0) begin
         leave = 1'b1;
      end else begin
         pool[m_own] = 1'b0;
         leave = !r[m_own];
`ifdef WB_ARB3_HOLD_LIMIT_EN
         if (m_run >= MAX_HOLD && pool != 3'b000) leave = 1'b1;
`endif
      end
      if (!leave) begin
         m_run++;
      end else begin
         nxt = -1;
         for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_last + k) % 3;
            if (nxt < 0 && pool[c]) nxt = c;
         end
         if (nxt >= 0) begin
            m_own   = nxt;
            m_last  = nxt;
            m_owner = nxt;
            m_run   = 1;
         end else begin
            m_own = -1;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".gnt"},   int'(gnt),   (m_own < 0) ? 0 : (1 << m_own));
      check({tag, ".sel"},   int'(sel),   m_owner);
      check({tag, ".busy"},  int'(busy),  (m_own < 0) ? 0 : 1);
      check({tag, ".owner"}, int'(owner), m_owner);
   endtask

   // Drive req at a falling edge, let one rising edge pass, compare at the next falling edge.
   task automatic cycle(input string tag, input logic [2:0] r);
      req = r;
      @(posedge clk);
      if (reset_n) model_step(r);
      @(negedge clk);
      compare_all(tag);
   endtask

   initial begin
      logic [2:0] r;
      reset_n = 1'b0;
      req     = 3'b111;
      model_reset();

      // Reset with all requests high: nothing granted.
      #3;
      compare_all("reset");
      repeat (2) @(negedge clk);
      compare_all("reset_clocked");
      reset_n = 1'b1;
      cycle("rst_release", 3'b111);
      check("rst_first_gnt", int'(gnt), 1);
      cycle("drop_all", 3'b000);

      // Single requester.
      for (int i = 0; i < 4; i++) cycle("single", 3'b100);
      check("single_gnt", int'(gnt), 4);
      cycle("single_rel", 3'b000);
      check("single_idle_sel", int'(sel), 2);
      cycle("idle", 3'b000);

      // Round robin with one-cycle drop by each owner.
      for (int n = 0; n < 4; n++) begin
         cycle("rr_hold", 3'b111);
         cycle("rr_hold", 3'b111);
         r = 3'b111;
         r[m_owner] = 1'b0;
         cycle("rr_drop", r);
      end
      cycle("rr_end", 3'b000);

      // Contended hold with two requesters.
      for (int i = 0; i < 14; i++) cycle("hold", 3'b011);
      cycle("hold_end", 3'b000);

      // Asynchronous reset while requester 1 owns the path.
      cycle("pre_rst", 3'b010);
      check("pre_rst_gnt", int'(gnt), 2);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_gnt", int'(gnt), 0);
      check("async_rst_busy", int'(busy), 0);
      model_reset();
      req = 3'b110;
      @(negedge clk);
      reset_n = 1'b1;
      cycle("post_rst", 3'b110);
      check("post_rst_gnt", int'(gnt), 2);
      cycle("post_rst_idle", 3'b000);

      // Uncontended long hold: never preempted.
      for (int i = 0; i < 20; i++) cycle("sat", 3'b001);
      check("sat_gnt", int'(gnt), 1);
      cycle("sat_end", 3'b000);

      // Random traffic, mostly level-held requests.
      r = 3'b000;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) < 3) r = 3'($urandom_range(0, 7));
         cycle("rand", r);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_arbiter3.md
# wb_arbiter3

Round-robin arbiter that shares the single-cycle CPU's 3-input write-back select mux between three requesters (ALU result, memory load data, PC+4 link value). It accepts per-requester request lines, issues a registered one-hot grant, and drives the 2-bit mux select so the granted source reaches the register-file write port. An optional hold limit stops one requester from keeping the shared path indefinitely.

## Interface
- MAX_HOLD, 8: maximum consecutive grant cycles per owner while others wait (≥2; used only with the hold limit compiled in)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req  input  3  request per source; bit i = requester i, level-held until done
- gnt  output  3  registered one-hot grant; 000 = no owner
- sel  output  2  mux select: 00 → in[0], 01 → in[1], 10 → in[2]; 11 never driven
- busy  output  1  1 while any grant is active
- owner  output  2  index of current/last owner (0..2)

## Operation
- States: IDLE (gnt=000), GRANT (exactly one gnt bit set).
- Rotation pointer `last` holds the most recent owner. Search order starts at last+1 mod 3 and wraps: 2→0→1→2.
- IDLE: when req≠000 is sampled, the first requester in rotation order is granted at that edge → GRANT. When req=000, remain in IDLE.
- GRANT, owner i:
  - req[i]=1 and hold limit not reached: keep the grant.
  - req[i]=0 sampled: release at that edge. If another req is set, grant goes straight to the next requester in rotation with no idle cycle. Otherwise → IDLE.
  - Hold limit reached (see Configuration) and another req is set: preempt at that edge to the next requester in rotation. The preempted requester keeps req high and re-competes normally.
- sel, owner and last update on every new grant. In IDLE they hold their last values, so the mux is never switched without a grant.
- Hold counter, $clog2(MAX_HOLD) bits: cleared on every new grant (including a handover to a different owner). Increments each cycle the grant is held. Saturates at MAX_HOLD-1.
- req bits set during GRANT for a non-owner are only considered at release or preemption. No request is queued after its req drops.
- gnt is purely registered; no combinational path from req to any output.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by system): gnt=000, sel=00, busy=0, owner=0, last=2 (requester 0 first in line), counter=0, state IDLE.
- Reset asserted mid-grant: all outputs return to reset values immediately, with no clock required.
- Request-to-grant latency: 1 cycle (req high at edge N → gnt high after edge N).
- Release-to-handover: 0 idle cycles (owner req low at edge N → new gnt after edge N).
- Simultaneous requests: resolved by the rotation pointer only; no fixed priority.
- Owner dropping req on the same edge the hold limit is reached: treated as a release; the outcome is identical.

## Configuration
- WB_ARB3_HOLD_LIMIT_EN defined: hold counter and preemption are compiled in. When the counter equals MAX_HOLD-1 and any other req bit is set, the owner is preempted at that edge. This gives a maximum of MAX_HOLD consecutive grant cycles while contended.
- Not defined: counter and preemption logic are absent and MAX_HOLD is ignored. An owner keeps the grant for as long as its req stays high. Rotation applies only at release.

## Test plan
- Reset: drive reset_n=0 with req=111 → gnt=000, sel=00, busy=0, owner=0. Release reset → one cycle later gnt=001, sel=00.
- Single requester: req=100 for 4 cycles, then 000 → gnt=100, sel=10 after 1 cycle, held 4 cycles. Then gnt=000, busy=0, sel stays 10.
- Round robin: req=111, each owner drops its req for 1 cycle after 2 cycles of grant → grant order 0,1,2,0 with no idle cycles between handovers.
- Hold limit (macro defined, MAX_HOLD=4): req=011 held constant → gnt=001 for exactly 4 cycles, then 010 for 4 cycles, alternating. Without the macro: gnt=001 indefinitely.
- Reset mid-operation: assert reset_n=0 asynchronously while gnt=010 → gnt=000 before the next clk edge. After release with req=110, requester 1 is granted first.
- Uncontended saturation (macro defined): req=001 for 20 cycles → gnt=001 throughout, no preemption, counter saturated at 3.
